// File: rtl/tx_fifo_arb_pkg.sv
// Shared types and sizing helpers for the tx_fifo write-port arbiter.
package tx_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MAX_PKT_LEN = 256;

  // Beat counter must be able to hold MAX_PKT_LEN itself
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/tx_fifo_arb_if.sv
// Packet-source and tx_fifo write-side bundle; master drives the sources, slave is the arbiter.
interface tx_fifo_arb_if
  import tx_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          i_afull;
  logic                          o_push;
  logic [DATA_WIDTH-1:0]         o_wdata;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_busy;
  logic                          o_err_len;
  logic [IDX_W-1:0]              o_err_src;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_afull,
    input  o_req_ready, o_push, o_wdata, o_grant, o_busy, o_err_len, o_err_src
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_afull,
    output o_req_ready, o_push, o_wdata, o_grant, o_busy, o_err_len, o_err_src
  );

endinterface

// File: rtl/tx_fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping, as one-hot plus index.
module rr_pick
  import tx_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               found
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk the rotated request vector starting just above ptr; first hit wins
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand_s   = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s       = IDX_W'((int'(ptr) + 1 + i) % NUM_REQ);
      hit_s        = req[cand_s] & ~found;
      pick[cand_s] = pick[cand_s] | hit_s;
      pick_idx     = hit_s ? cand_s : pick_idx;
      found        = found | req[cand_s];
    end
  end

endmodule

// File: rtl/tx_fifo_arb.sv
// Round-robin packet arbiter sharing the tx_fifo write port; grant locks until last beat or MAX_PKT_LEN.
module tx_fifo_arb
  import tx_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ     = DEF_NUM_REQ,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  tx_fifo_arb_if.slave  bus
);

  localparam int                 CNT_W    = cnt_width(MAX_PKT_LEN);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_t            state_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  push_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  busy_r;
  logic                  err_len_r;
  logic [IDX_W-1:0]      err_src_r;

  logic [NUM_REQ-1:0]    ready_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] beat_data_s;
  logic                  beat_last_s;
  logic [NUM_REQ-1:0]    pick_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_found_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.i_req_valid),
    .ptr      (ptr_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .found    (pick_found_s)
  );

  // Owner's ready follows afull directly; beat data/last via AND-OR mux on the one-hot grant
  always_comb begin
    ready_s     = '0;
    beat_data_s = '0;
    if (state_r == XFER && !bus.i_afull) begin
      ready_s = grant_r;
    end else begin
      ready_s = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      beat_data_s = beat_data_s |
                    ({DATA_WIDTH{grant_r[k]}} & bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH]);
    end
    accept_s    = |(ready_s & bus.i_req_valid);
    beat_last_s = |(grant_r & bus.i_req_last);
  end

  // Arbitration FSM; every write-side output is a register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      ptr_r     <= PTR_RST;
      cnt_r     <= '0;
      grant_r   <= '0;
      idx_r     <= '0;
      push_r    <= 1'b0;
      wdata_r   <= '0;
      busy_r    <= 1'b0;
      err_len_r <= 1'b0;
      err_src_r <= '0;
    end else begin
      push_r    <= 1'b0;
      err_len_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (pick_found_s) begin
            grant_r <= pick_s;
            idx_r   <= pick_idx_s;
            busy_r  <= 1'b1;
            state_r <= XFER;
          end else begin
            grant_r <= '0;
            busy_r  <= 1'b0;
          end
        end
        XFER: begin
          if (accept_s) begin
            push_r  <= 1'b1;
            wdata_r <= beat_data_s;
            // Oversize packets are cut here; the rest re-arbitrates as a fresh packet
            if (beat_last_s || cnt_r == LAST_CNT) begin
              if (!beat_last_s) begin
                err_len_r <= 1'b1;
                err_src_r <= idx_r;
              end else begin
                err_len_r <= 1'b0;
              end
              ptr_r   <= idx_r;
              cnt_r   <= '0;
              grant_r <= '0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.o_req_ready = ready_s;
  assign bus.o_push      = push_r;
  assign bus.o_wdata     = wdata_r;
  assign bus.o_grant     = grant_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_err_len   = err_len_r;
  assign bus.o_err_src   = err_src_r;

endmodule

// File: tb/tb_tx_fifo_arb.sv
// Randomised bench for tx_fifo_arb against a cycle-level behavioural model of the arbitration rules.
module tb_tx_fifo_arb;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_fifo_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  tx_fifo_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t srcq [N][$];
  int gap [N];
  int afull_hold, vprob, aprob;
  int n_checks = 0, n_fail = 0;

  // reference model state: owner -1 means no packet in progress
  int m_owner = -1, m_ptr = N-1, m_cnt = 0, m_err_src = 0;
  bit m_push = 1'b0, m_err = 1'b0, m_live = 1'b0;
  logic [DW-1:0] m_wdata = '0;

  int push_log [$];
  int grant_log [$];
  int err_cnt, stall_cnt, last_err_src;
  logic [N-1:0] prev_grant;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push_pkt(input int s, input int len, input int base);
    for (int b = 0; b < len; b++) srcq[s].push_back('{d: DW'(base + b), l: (b == len-1)});
  endtask

  task automatic clear_logs();
    push_log.delete(); grant_log.delete();
    err_cnt = 0; stall_cnt = 0; last_err_src = -1; prev_grant = '0;
  endtask

  task automatic do_cycle(input bit r);
    logic [N-1:0] v, er;
    logic af;
    int c;
    bit found;
    @(negedge clk);
    rst = r;
    for (int k = 0; k < N; k++) begin
      v[k] = (srcq[k].size() > 0) && (gap[k] == 0) && ($urandom_range(99) < vprob);
      bus.i_req_data[k*DW +: DW] = (srcq[k].size() > 0) ? srcq[k][0].d : DW'($urandom);
      bus.i_req_last[k] = (srcq[k].size() > 0) ? srcq[k][0].l : 1'($urandom);
    end
    af = (afull_hold > 0) || ($urandom_range(99) < aprob);
    bus.i_req_valid = v;
    bus.i_afull = af;
    #1;
    er = '0;
    if (m_owner >= 0 && !af) er[m_owner] = 1'b1;
    if (m_live) begin
      chk("ready", bus.o_req_ready, er);
      chk("push", bus.o_push, m_push);
      chk("wdata", bus.o_wdata, m_wdata);
      chk("grant", bus.o_grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("busy", bus.o_busy, (m_owner >= 0));
      chk("err_len", bus.o_err_len, m_err);
      chk("err_src", bus.o_err_src, m_err_src);
      if (bus.o_push === 1'b1) push_log.push_back(int'(bus.o_wdata));
      if (bus.o_grant != '0 && prev_grant == '0) grant_log.push_back(onehot_idx(bus.o_grant));
      prev_grant = bus.o_grant;
      if (bus.o_err_len === 1'b1) begin err_cnt++; last_err_src = int'(bus.o_err_src); end
      if (bus.o_busy === 1'b1 && bus.o_req_ready == '0) stall_cnt++;
    end
    if (r) begin
      m_owner = -1; m_ptr = N-1; m_cnt = 0; m_push = 0; m_wdata = '0;
      m_err = 0; m_err_src = 0; m_live = 1'b1;
    end else begin
      m_push = 0; m_err = 0;
      if (m_owner < 0) begin
        found = 0;
        for (int i = 1; i <= N; i++) begin
          c = (m_ptr + i) % N;
          if (!found && v[c]) begin found = 1; m_owner = c; m_cnt = 0; end
        end
      end else if (v[m_owner] && !af) begin
        m_push = 1; m_wdata = srcq[m_owner][0].d; m_cnt++;
        if (srcq[m_owner][0].l || m_cnt == MAXL) begin
          if (!srcq[m_owner][0].l) begin m_err = 1; m_err_src = m_owner; end
          m_ptr = m_owner; m_owner = -1; m_cnt = 0;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (v[k] && er[k]) void'(srcq[k].pop_front());
      if (gap[k] > 0) gap[k]--;
    end
    if (afull_hold > 0) afull_hold--;
  endtask

  function automatic bit all_empty();
    bit e = 1;
    for (int k = 0; k < N; k++) if (srcq[k].size() != 0) e = 0;
    return e;
  endfunction

  task automatic drain(input int budget);
    int c = 0;
    while ((!all_empty() || m_owner >= 0 || m_push) && c < budget) begin
      do_cycle(1'b0); c++;
    end
    chk("drain_budget", (c < budget), 1);
  endtask

  task automatic run_until(input int own, input int cnt);
    int c = 0;
    while (!(m_owner == own && m_cnt == cnt) && c < 50) begin
      do_cycle(1'b0); c++;
    end
    chk("reach_point", (c < 50), 1);
  endtask

  // Reset, then pin the post-reset outputs just after the resetting edge
  task automatic do_reset(input bit clear_q);
    if (clear_q) for (int k = 0; k < N; k++) srcq[k].delete();
    for (int k = 0; k < N; k++) gap[k] = 0;
    afull_hold = 0;
    do_cycle(1'b1);
    #5;
    chk("rst_push", bus.o_push, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_err_len, 0);
    clear_logs();
  endtask

  initial begin
    bus.i_req_valid = '0; bus.i_req_data = '0; bus.i_req_last = '0; bus.i_afull = 1'b0;
    vprob = 100; aprob = 0; afull_hold = 0;
    for (int k = 0; k < N; k++) gap[k] = 0;
    clear_logs();

    // single 3-beat packet from source 0
    do_reset(1'b1);
    push_pkt(0, 3, 8'h11);
    srcq[0][1].d = 8'h22; srcq[0][2].d = 8'h33;
    drain(40);
    chk("t1_npush", push_log.size(), 3);
    if (push_log.size() == 3) begin
      chk("t1_d0", push_log[0], 8'h11); chk("t1_d1", push_log[1], 8'h22); chk("t1_d2", push_log[2], 8'h33);
    end
    chk("t1_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // all sources busy: round-robin order
    do_reset(1'b1);
    for (int p = 0; p < 2; p++) for (int k = 0; k < N; k++) push_pkt(k, 2, k*16 + p*4);
    drain(100);
    chk("t2_ngrant", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], i % N);
    chk("t2_npush", push_log.size(), 16);
    if (push_log.size() == 16) chk("t2_contig", push_log[2], 8'h10);

    // afull stall mid-packet on source 2
    do_reset(1'b1);
    push_pkt(2, 4, 8'h40);
    run_until(2, 2);
    afull_hold = 5;
    drain(40);
    chk("t3_stall", stall_cnt, 5);
    chk("t3_npush", push_log.size(), 4);
    if (push_log.size() == 4) chk("t3_last", push_log[3], 8'h43);

    // oversize packet from source 1
    do_reset(1'b1);
    push_pkt(1, 6, 8'h60);
    drain(60);
    chk("t4_npush", push_log.size(), 6);
    chk("t4_errcnt", err_cnt, 1);
    chk("t4_errsrc", last_err_src, 1);
    chk("t4_ngrant", grant_log.size(), 2);

    // reset while source 3 is mid-packet; the beat handshaken in the reset cycle is lost
    do_reset(1'b1);
    push_pkt(3, 4, 8'h70);
    run_until(3, 2);
    push_pkt(0, 2, 8'h80);
    do_reset(1'b0);
    drain(60);
    chk("t5_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("t5_second", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    chk("t5_npush", push_log.size(), 3);
    if (push_log.size() == 3) chk("t5_tail", push_log[2], 8'h73);

    // valid gap on owner while another source waits
    do_reset(1'b1);
    push_pkt(0, 3, 8'h90);
    push_pkt(1, 2, 8'hA0);
    run_until(0, 1);
    gap[0] = 3;
    drain(60);
    chk("t6_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin chk("t6_g0", grant_log[0], 0); chk("t6_g1", grant_log[1], 1); end
    if (push_log.size() == 5) begin chk("t6_d2", push_log[2], 8'h92); chk("t6_d3", push_log[3], 8'hA0); end
    else chk("t6_npush", push_log.size(), 5);

    // random traffic, gaps, afull and occasional reset
    do_reset(1'b1);
    vprob = 70; aprob = 20;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int s;
      s = $urandom_range(N-1);
      if (srcq[s].size() < 4) push_pkt(s, $urandom_range(6, 1), $urandom_range(255));
      if ($urandom_range(49) == 0) gap[$urandom_range(N-1)] = $urandom_range(4, 1);
      do_cycle($urandom_range(399) == 0);
    end
    vprob = 100; aprob = 0;
    drain(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
